// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Raster timing generator for 800x600@60 Hz on a 40 MHz pixel clock (all
//   geometry is parameterised). It keeps a horizontal counter (hcnt) and a
//   vertical counter (vcnt) and registers a decode of them every clock, so
//   every output lags the counters by exactly one cycle.
//
//   Optional feature macro: VGA_TIMING_FRAME_COUNTER_EN
//     When defined, the FrameCount output is added. It counts FrameStart
//     pulses, not counting the first pulse after reset.
//
// Ports
//   Clock       in   1   pixel clock
//   Reset       in   1   asynchronous, active-low reset
//   X           out  11  horizontal position (registered hcnt)
//   Y           out  10  vertical position (registered vcnt)
//   Visible     out  1   X < H_VISIBLE and Y < V_VISIBLE
//   LineStart   out  1   high for one cycle when X == 0
//   FrameStart  out  1   high for one cycle when X == 0 and Y == 0
//   HSync       out  1   horizontal sync, polarity set by SYNC_POS,
//                        delayed by PIPE_DELAY extra stages
//   VSync       out  1   vertical sync, polarity set by SYNC_POS,
//                        delayed by PIPE_DELAY extra stages
//   FrameCount  out  16  frame counter (only with VGA_TIMING_FRAME_COUNTER_EN)
module vga_timing_gen #(
  parameter int H_VISIBLE  = 800,
  parameter int H_FRONT    = 40,
  parameter int H_SYNC     = 128,
  parameter int H_BACK     = 88,
  parameter int V_VISIBLE  = 600,
  parameter int V_FRONT    = 1,
  parameter int V_SYNC     = 4,
  parameter int V_BACK     = 23,
  parameter int SYNC_POS   = 1,
  parameter int PIPE_DELAY = 0
) (
  input  logic        Clock,
  input  logic        Reset,
  output logic [10:0] X,
  output logic [9:0]  Y,
  output logic        Visible,
  output logic        LineStart,
  output logic        FrameStart,
  output logic        HSync,
  output logic        VSync
`ifdef VGA_TIMING_FRAME_COUNTER_EN
  ,
  output logic [15:0] FrameCount
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Geometry constants, sized to the counter widths.
  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] H_SYNC_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_VIS_END  = 10'(V_VISIBLE);
  localparam logic [9:0]  V_SYNC_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0]  V_SYNC_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  localparam logic SYNC_ACT  = (SYNC_POS != 0);
  localparam logic SYNC_IDLE = (SYNC_POS == 0);

  logic [10:0] hcnt_reg;
  logic [9:0]  vcnt_reg;
  logic        hs_reg;
  logic        vs_reg;
  logic        h_last;
  logic        at_origin;
  logic        hs_next;
  logic        vs_next;

  assign h_last    = (hcnt_reg == H_LAST);
  assign at_origin = (hcnt_reg == '0) && (vcnt_reg == '0);

  // Counters: both wrap on the same edge at the last pixel of the frame.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      hcnt_reg <= '0;
      vcnt_reg <= '0;
    end else begin
      if (h_last) begin
        hcnt_reg <= '0;
        if (vcnt_reg == V_LAST) begin
          vcnt_reg <= '0;
        end else begin
          vcnt_reg <= vcnt_reg + 10'd1;
        end
      end else begin
        hcnt_reg <= hcnt_reg + 11'd1;
      end
    end
  end

  // VSync is a pure function of vcnt, so it can only change where vcnt
  // changes, i.e. at the hcnt wrap.
  always_comb begin
    hs_next = SYNC_IDLE;
    vs_next = SYNC_IDLE;
    if ((hcnt_reg >= H_SYNC_BEG) && (hcnt_reg < H_SYNC_END)) begin
      hs_next = SYNC_ACT;
    end
    if ((vcnt_reg >= V_SYNC_BEG) && (vcnt_reg < V_SYNC_END)) begin
      vs_next = SYNC_ACT;
    end
  end

  // Output register stage. Reset clears the decodes to 0 (not to the value
  // for the origin), so the first origin pulse appears only after a real edge.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      X          <= '0;
      Y          <= '0;
      Visible    <= 1'b0;
      LineStart  <= 1'b0;
      FrameStart <= 1'b0;
      hs_reg     <= SYNC_IDLE;
      vs_reg     <= SYNC_IDLE;
    end else begin
      X          <= hcnt_reg;
      Y          <= vcnt_reg;
      Visible    <= (hcnt_reg < H_VIS_END) && (vcnt_reg < V_VIS_END);
      LineStart  <= (hcnt_reg == '0);
      FrameStart <= at_origin;
      hs_reg     <= hs_next;
      vs_reg     <= vs_next;
    end
  end

  // Sync-only delay line so sync lines up with a downstream colour pipeline.
  generate
    if (PIPE_DELAY == 0) begin : g_no_delay
      assign HSync = hs_reg;
      assign VSync = vs_reg;
    end else begin : g_delay
      logic [PIPE_DELAY-1:0] hs_dly_reg;
      logic [PIPE_DELAY-1:0] vs_dly_reg;

      always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
          hs_dly_reg <= {PIPE_DELAY{SYNC_IDLE}};
          vs_dly_reg <= {PIPE_DELAY{SYNC_IDLE}};
        end else begin
          hs_dly_reg[0] <= hs_reg;
          vs_dly_reg[0] <= vs_reg;
          for (int i = 1; i < PIPE_DELAY; i++) begin
            hs_dly_reg[i] <= hs_dly_reg[i-1];
            vs_dly_reg[i] <= vs_dly_reg[i-1];
          end
        end
      end

      assign HSync = hs_dly_reg[PIPE_DELAY-1];
      assign VSync = vs_dly_reg[PIPE_DELAY-1];
    end
  endgenerate

`ifdef VGA_TIMING_FRAME_COUNTER_EN
  // first_seen_reg skips the first origin after reset, so frame 0 reads 0.
  logic        first_seen_reg;
  logic [15:0] frame_cnt_reg;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      first_seen_reg <= 1'b0;
      frame_cnt_reg  <= '0;
    end else if (at_origin) begin
      first_seen_reg <= 1'b1;
      if (first_seen_reg) begin
        frame_cnt_reg <= frame_cnt_reg + 16'd1;
      end
    end
  end

  assign FrameCount = frame_cnt_reg;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen.
// dut_a: default 800x600 geometry, active-high sync, no sync delay.
// dut_b: small 32x18 geometry (16/4/8/4, 12/1/2/3), active-low sync, PIPE_DELAY=3,
//        so whole frames (576 clocks) can be run quickly.
// samp counts rising edges since the last reset release; sample k is taken on
// the falling edge after rising edge k and shows the counters of edge k-1.
module tb_vga_timing_gen;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  always #5 Clock = ~Clock;

  logic [10:0] a_x, b_x;
  logic [9:0]  a_y, b_y;
  logic a_vis, a_ls, a_fs, a_hs, a_vs;
  logic b_vis, b_ls, b_fs, b_hs, b_vs;
`ifdef VGA_TIMING_FRAME_COUNTER_EN
  logic [15:0] a_fc, b_fc;
`endif

  int checks = 0;
  int errors = 0;
  int samp = 0;

  vga_timing_gen dut_a (
    .Clock(Clock), .Reset(Reset), .X(a_x), .Y(a_y), .Visible(a_vis),
    .LineStart(a_ls), .FrameStart(a_fs), .HSync(a_hs), .VSync(a_vs)
`ifdef VGA_TIMING_FRAME_COUNTER_EN
    , .FrameCount(a_fc)
`endif
  );

  vga_timing_gen #(
    .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
    .V_VISIBLE(12), .V_FRONT(1), .V_SYNC(2), .V_BACK(3),
    .SYNC_POS(0), .PIPE_DELAY(3)
  ) dut_b (
    .Clock(Clock), .Reset(Reset), .X(b_x), .Y(b_y), .Visible(b_vis),
    .LineStart(b_ls), .FrameStart(b_fs), .HSync(b_hs), .VSync(b_vs)
`ifdef VGA_TIMING_FRAME_COUNTER_EN
    , .FrameCount(b_fc)
`endif
  );

  task automatic tick();
    @(negedge Clock);
    samp++;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    repeat (5) @(negedge Clock);
    checks++; if (a_x !== 11'd0) begin errors++; $display("FAIL rst_a_x got %0d want 0", a_x); end
    checks++; if (a_y !== 10'd0) begin errors++; $display("FAIL rst_a_y got %0d want 0", a_y); end
    checks++; if (a_vis !== 1'b0) begin errors++; $display("FAIL rst_a_vis got %b want 0", a_vis); end
    checks++; if (a_ls !== 1'b0) begin errors++; $display("FAIL rst_a_ls got %b want 0", a_ls); end
    checks++; if (a_fs !== 1'b0) begin errors++; $display("FAIL rst_a_fs got %b want 0", a_fs); end
    checks++; if (a_hs !== 1'b0) begin errors++; $display("FAIL rst_a_hs got %b want 0", a_hs); end
    checks++; if (a_vs !== 1'b0) begin errors++; $display("FAIL rst_a_vs got %b want 0", a_vs); end
    checks++; if (b_hs !== 1'b1) begin errors++; $display("FAIL rst_b_hs got %b want 1", b_hs); end
    checks++; if (b_vs !== 1'b1) begin errors++; $display("FAIL rst_b_vs got %b want 1", b_vs); end
`ifdef VGA_TIMING_FRAME_COUNTER_EN
    checks++; if (b_fc !== 16'd0) begin errors++; $display("FAIL rst_b_fc got %0d want 0", b_fc); end
`endif
    Reset = 1'b1;
    samp = 0;
    tick();
    checks++; if (a_x !== 11'd0 || a_y !== 10'd0) begin errors++; $display("FAIL first_a_xy got (%0d,%0d) want (0,0)", a_x, a_y); end
    checks++; if (a_vis !== 1'b1) begin errors++; $display("FAIL first_a_vis got %b want 1", a_vis); end
    checks++; if (a_ls !== 1'b1) begin errors++; $display("FAIL first_a_ls got %b want 1", a_ls); end
    checks++; if (a_fs !== 1'b1) begin errors++; $display("FAIL first_a_fs got %b want 1", a_fs); end
    $display("test_reset done: sample %0d", samp);
  endtask

  // One full line of dut_a plus the start of the next one (samples 2..1057).
  task automatic test_line();
    int vis_cnt = 0;
    int hs_cnt = 0;
    int h;
    int v;
    while (samp < 1057) begin
      tick();
      h = (samp - 1) % 1056;
      v = (samp - 1) / 1056;
      if (samp <= 1056) begin
        if (a_vis === 1'b1) vis_cnt++;
        if (a_hs === 1'b1) hs_cnt++;
      end
      checks++; if (a_x !== 11'(h) || a_y !== 10'(v)) begin errors++; $display("FAIL line_xy s=%0d got (%0d,%0d) want (%0d,%0d)", samp, a_x, a_y, h, v); end
      checks++; if (a_vis !== (h < 800 && v < 600)) begin errors++; $display("FAIL line_vis s=%0d got %b", samp, a_vis); end
      checks++; if (a_ls !== (h == 0)) begin errors++; $display("FAIL line_ls s=%0d got %b want %b", samp, a_ls, (h == 0)); end
      checks++; if (a_fs !== 1'b0) begin errors++; $display("FAIL line_fs s=%0d got %b want 0", samp, a_fs); end
      checks++; if (a_hs !== (h >= 840 && h < 968)) begin errors++; $display("FAIL line_hs s=%0d x=%0d got %b", samp, h, a_hs); end
      checks++; if (a_vs !== 1'b0) begin errors++; $display("FAIL line_vs s=%0d got %b want 0", samp, a_vs); end
    end
    // Sample 1 (visible) was consumed by test_reset.
    checks++; if (vis_cnt != 799) begin errors++; $display("FAIL line_vis_count got %0d want 799", vis_cnt); end
    checks++; if (hs_cnt != 128) begin errors++; $display("FAIL line_hs_count got %0d want 128", hs_cnt); end
    checks++; if (a_ls !== 1'b1 || a_y !== 10'd1) begin errors++; $display("FAIL line_wrap got ls=%b y=%0d want ls=1 y=1", a_ls, a_y); end
    $display("test_line done: visible=%0d hsync=%0d", vis_cnt, hs_cnt);
  endtask

  // Three frames of dut_b (samples 1058..2785), including the delayed,
  // active-low sync outputs.
  task automatic test_frame();
    int fs_cnt = 0;
    int y_max = 0;
    int h, v, d, dh, dv;
    logic hs_exp, vs_exp;
    while (samp < 2785) begin
      tick();
      h = (samp - 1) % 32;
      v = ((samp - 1) / 32) % 18;
      d = samp - 4;
      hs_exp = 1'b1;
      vs_exp = 1'b1;
      if (d >= 0) begin
        dh = d % 32;
        dv = (d / 32) % 18;
        hs_exp = !(dh >= 20 && dh < 28);
        vs_exp = !(dv >= 13 && dv < 15);
      end
      if (b_fs === 1'b1) fs_cnt++;
      if (int'(b_y) > y_max) y_max = int'(b_y);
      checks++; if (b_x !== 11'(h) || b_y !== 10'(v)) begin errors++; $display("FAIL frame_xy s=%0d got (%0d,%0d) want (%0d,%0d)", samp, b_x, b_y, h, v); end
      checks++; if (b_vis !== (h < 16 && v < 12)) begin errors++; $display("FAIL frame_vis s=%0d got %b", samp, b_vis); end
      checks++; if (b_ls !== (h == 0)) begin errors++; $display("FAIL frame_ls s=%0d got %b", samp, b_ls); end
      checks++; if (b_fs !== (h == 0 && v == 0)) begin errors++; $display("FAIL frame_fs s=%0d got %b", samp, b_fs); end
      checks++; if (b_hs !== hs_exp) begin errors++; $display("FAIL frame_hs s=%0d got %b want %b", samp, b_hs, hs_exp); end
      checks++; if (b_vs !== vs_exp) begin errors++; $display("FAIL frame_vs s=%0d got %b want %b", samp, b_vs, vs_exp); end
      checks++; if (a_x !== 11'((samp - 1) % 1056) || a_y !== 10'((samp - 1) / 1056)) begin errors++; $display("FAIL frame_a_xy s=%0d got (%0d,%0d)", samp, a_x, a_y); end
`ifdef VGA_TIMING_FRAME_COUNTER_EN
      if (h == 0 && v == 0) begin
        checks++; if (b_fc !== 16'((samp - 1) / 576)) begin errors++; $display("FAIL frame_fc s=%0d got %0d want %0d", samp, b_fc, (samp - 1) / 576); end
      end
`endif
    end
    checks++; if (fs_cnt != 3) begin errors++; $display("FAIL frame_fs_count got %0d want 3", fs_cnt); end
    checks++; if (y_max != 17) begin errors++; $display("FAIL frame_y_max got %0d want 17", y_max); end
    $display("test_frame done: framestarts=%0d ymax=%0d", fs_cnt, y_max);
  endtask

  // Reset while dut_b is at (25,5) with its sync delay line full of active
  // values; all outputs must drop without a clock edge.
  task automatic test_midframe_reset();
    int guard = 0;
    while (!(((samp - 1) % 576) == 5 * 32 + 25) && guard < 700) begin
      tick();
      guard++;
    end
    checks++; if (guard >= 700) begin errors++; $display("FAIL mid_reach got timeout want (25,5)"); end
    checks++; if (b_x !== 11'd25 || b_y !== 10'd5 || b_hs !== 1'b0) begin errors++; $display("FAIL mid_before got (%0d,%0d) hs=%b want (25,5) hs=0", b_x, b_y, b_hs); end
    Reset = 1'b0;
    #1;
    checks++; if (b_x !== 11'd0 || b_y !== 10'd0) begin errors++; $display("FAIL mid_async_xy got (%0d,%0d) want (0,0)", b_x, b_y); end
    checks++; if (b_vis !== 1'b0 || b_ls !== 1'b0 || b_fs !== 1'b0) begin errors++; $display("FAIL mid_async_flags got vis=%b ls=%b fs=%b want 000", b_vis, b_ls, b_fs); end
    checks++; if (b_hs !== 1'b1 || b_vs !== 1'b1) begin errors++; $display("FAIL mid_async_sync got hs=%b vs=%b want 11", b_hs, b_vs); end
    checks++; if (a_x !== 11'd0 || a_vis !== 1'b0) begin errors++; $display("FAIL mid_async_a got x=%0d vis=%b want 0,0", a_x, a_vis); end
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    samp = 0;
    tick();
    checks++; if (b_x !== 11'd0 || b_y !== 10'd0 || b_fs !== 1'b1 || b_ls !== 1'b1) begin errors++; $display("FAIL mid_restart_b got (%0d,%0d) fs=%b ls=%b", b_x, b_y, b_fs, b_ls); end
    checks++; if (a_x !== 11'd0 || a_y !== 10'd0 || a_fs !== 1'b1) begin errors++; $display("FAIL mid_restart_a got (%0d,%0d) fs=%b", a_x, a_y, a_fs); end
`ifdef VGA_TIMING_FRAME_COUNTER_EN
    checks++; if (b_fc !== 16'd0) begin errors++; $display("FAIL mid_restart_fc got %0d want 0", b_fc); end
`endif
    while (samp < 8) begin
      tick();
      checks++; if (b_hs !== 1'b1 || b_vs !== 1'b1) begin errors++; $display("FAIL mid_no_pulse s=%0d got hs=%b vs=%b want 11", samp, b_hs, b_vs); end
      checks++; if (b_x !== 11'(samp - 1)) begin errors++; $display("FAIL mid_x s=%0d got %0d want %0d", samp, b_x, samp - 1); end
    end
    $display("test_midframe_reset done");
  endtask

`ifdef VGA_TIMING_FRAME_COUNTER_EN
  task automatic test_frame_counter();
    int seen = 1;
    while (samp < 1153) begin
      tick();
      if (b_fs === 1'b1) begin
        checks++; if (b_fc !== 16'(seen)) begin errors++; $display("FAIL fc_step s=%0d got %0d want %0d", samp, b_fc, seen); end
        seen++;
      end
    end
    checks++; if (seen != 3) begin errors++; $display("FAIL fc_frames got %0d want 3", seen); end
    $display("test_frame_counter done: count=%0d", b_fc);
  endtask
`endif

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_midframe_reset();
`ifdef VGA_TIMING_FRAME_COUNTER_EN
    test_frame_counter();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
